util_fifo_axis_reader: RTL and testbench
========================================

// Module: util_fifo_axis_reader
// PURPOSE
//  Read-side drain for util_fifo_simple. Pops words from the FIFO's show-ahead head and emits them
//  as an AXI-Stream master with TLAST every PKT_LEN beats. Sits between a FIFO and a DMA/stream sink.
//  A 2-entry registered output buffer removes any combinational path from m_axis_tready to fifo_rden.
// PARAMETERS
//  DATA_WIDTH  32   width of FIFO word and m_axis_tdata
//  DEPTH       128  depth of the attached FIFO; fifo_dcnt is $clog2(DEPTH)+1 bits wide
//  PKT_LEN     16   beats per packet, legal range 1..DEPTH
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              synchronous reset, active low
//  clr            in   1              synchronous soft clear (same effect as reset, FIFO untouched)
//  fifo_dout      in   DATA_WIDTH     FIFO head word, valid while fifo_empty=0
//  fifo_dcnt      in   $clog2(DEPTH)+1  FIFO occupancy
//  fifo_empty     in   1              FIFO empty
//  fifo_rden      out  1              FIFO pop strobe (combinational)
//  m_axis_tdata   out  DATA_WIDTH     stream data
//  m_axis_tvalid  out  1              stream valid
//  m_axis_tready  in   1              stream ready
//  m_axis_tlast   out  1              last beat of packet
//  pkt_done       out  1              1-cycle pulse when a TLAST beat handshakes
// BEHAVIOUR
//  - One clock, clk. Reset synchronous, active low on rst_n; clr has identical effect.
//  - Reset/clr: buffer occupancy occ=0, tvalid=0, tlast=0, tdata=0, pkt_done=0,
//    beat counter=0, FSM=IDLE; fifo_rden=0 during the reset/clr cycle.
//  - Buffer: 2-entry FIFO of {last,data}. Head drives tdata/tlast; tvalid = (occ!=0).
//  - fifo_rden = ~fifo_empty & (occ<2) & (FSM==STREAM) & ~clr & rst_n. No dependence on tready.
//  - Pop: on fifo_rden, fifo_dout captured with last=(beat==PKT_LEN-1) in the same cycle.
//    Beat counter increments, wrapping to 0 after PKT_LEN-1; PKT_LEN=1 -> every beat has last=1.
//  - Pop and output handshake in the same cycle: occ unchanged; sustained 1 beat/clk when tready=1.
//  - Latency: word at FIFO head with empty=0 in cycle N (occ<2, STREAM) -> tvalid=1 in cycle N+1.
//  - AXIS rules: once tvalid=1, tdata/tlast held stable until tready=1; tvalid never drops without
//    a handshake except on reset/clr (buffered words are discarded).
//  - FSM: IDLE -> STREAM (condition per CONFIGURATION); STREAM -> IDLE when the pop with last=1
//    occurs. Pops are never gated mid-packet except by fifo_empty or occ=2.
//  - pkt_done = registered (tvalid & tready & tlast); asserted the cycle after the TLAST handshake.
//  - Never pops an empty FIFO; never overwrites a buffer entry; occ range 0..2.
// CONFIGURATION
//  UTIL_FIFO_RD_PKTWAIT_EN defined:
//    IDLE -> STREAM only when fifo_dcnt >= PKT_LEN, so a started packet streams without FIFO stalls;
//    fifo_dcnt is compared zero-extended, full width.
//  UTIL_FIFO_RD_PKTWAIT_EN undefined:
//    IDLE -> STREAM unconditionally the cycle after reset/packet end; fifo_dcnt unused;
//    words are drained as soon as available.
// TESTING
//  T1 PKT_LEN=4, FIFO preloaded with 0x10..0x17, tready=1
//     -> 8 consecutive beats 0x10..0x17, tlast on 0x13 and 0x17, pkt_done twice.
//  T2 tready low 5 cycles mid-stream
//     -> occ=2, fifo_rden=0, tdata frozen; resume with no loss or duplication.
//  T3 PKTWAIT_EN, PKT_LEN=4, write 3 words -> no tvalid for 20 cycles;
//     write 4th -> 4 beats 0x10..0x13, last on 4th.
//  T4 no macro, FIFO empty -> write single word 0xA5 in cycle N
//     -> fifo_rden at N+1 (empty falls), tvalid at N+2.
//  T5 clr asserted after 2 of 4 beats -> tvalid=0 next cycle;
//     next packet tlast on its 4th beat (counter restarted).
//  T6 PKT_LEN=1, random tready, 100 words -> every beat tlast=1,
//     data order preserved, AXIS stability assertions hold.

Source files
------------

// File: rtl/util_fifo_axis_reader_if.sv
`default_nettype none
// ============================================================================
// Interface : util_fifo_axis_reader_if
// Purpose   : FIFO read port plus AXI-Stream master bundle for util_fifo_axis_reader
// Revision  : 1.0
// ============================================================================
interface util_fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
);
    logic [DATA_WIDTH-1:0]     fifo_dout;
    logic [$clog2(DEPTH):0]    fifo_dcnt;
    logic                      fifo_empty;
    logic                      fifo_rden;
    logic [DATA_WIDTH-1:0]     m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;
    logic                      pkt_done;

    modport master (
        input  fifo_dout, fifo_dcnt, fifo_empty, m_axis_tready,
        output fifo_rden, m_axis_tdata, m_axis_tvalid, m_axis_tlast, pkt_done
    );

    modport slave (
        output fifo_dout, fifo_dcnt, fifo_empty, m_axis_tready,
        input  fifo_rden, m_axis_tdata, m_axis_tvalid, m_axis_tlast, pkt_done
    );
endinterface
`default_nettype wire

// File: rtl/util_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : util_fifo_axis_reader
// Purpose  : drains a show-ahead FIFO into an AXI-Stream master, TLAST every PKT_LEN beats.
//            Define UTIL_FIFO_RD_PKTWAIT_EN to start a packet only when a whole one is queued.
// Revision : 1.0
// ============================================================================
module util_fifo_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int PKT_LEN    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    util_fifo_axis_reader_if.master    bus
);

    localparam int                    c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int                    c_DCNT_W    = $clog2(DEPTH) + 1;
    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_occ;
    logic [DATA_WIDTH-1:0]   r_data0;
    logic [DATA_WIDTH-1:0]   r_data1;
    logic                    r_last0;
    logic                    r_last1;
    logic [c_BEAT_W-1:0]     r_beat;
    logic                    r_pkt_done;

    logic                    w_pop;
    logic                    w_pop_last;
    logic                    w_hs;
    logic                    w_start;

`ifdef UTIL_FIFO_RD_PKTWAIT_EN
    logic [c_DCNT_W-1:0]     w_dcnt;
    assign w_dcnt  = bus.fifo_dcnt;
    assign w_start = (32'(w_dcnt) >= 32'(PKT_LEN));
`else
    logic [c_DCNT_W-1:0]     w_dcnt_unused;
    assign w_dcnt_unused = bus.fifo_dcnt;
    assign w_start       = 1'b1;
`endif

    // Pop decision never looks at tready: the 2-deep buffer absorbs the stall.
    assign w_pop      = ~bus.fifo_empty & (r_occ < 2'd2) & (r_state == ST_STREAM) & ~clr & rst_n;
    assign w_pop_last = (r_beat == c_LAST_BEAT);
    assign w_hs       = (r_occ != 2'd0) & bus.m_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start)             w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_pop && w_pop_last) w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_occ      <= 2'd0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_beat     <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= w_hs & r_last0;

            if (w_pop) begin
                r_beat <= w_pop_last ? '0 : r_beat + 1'b1;
            end

            // Entry 0 is always the head; entry 1 only holds a word while occ==2.
            case ({w_pop, w_hs})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= bus.fifo_dout;
                        r_last0 <= w_pop_last;
                    end else begin
                        r_data1 <= bus.fifo_dout;
                        r_last1 <= w_pop_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data0 <= bus.fifo_dout;
                        r_last0 <= w_pop_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= bus.fifo_dout;
                        r_last1 <= w_pop_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.fifo_rden     = w_pop;
    assign bus.m_axis_tdata  = r_data0;
    assign bus.m_axis_tvalid = (r_occ != 2'd0);
    assign bus.m_axis_tlast  = r_last0;
    assign bus.pkt_done      = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_util_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_util_fifo_axis_reader
// Purpose  : bench for util_fifo_axis_reader; instance A uses PKT_LEN=4, instance B PKT_LEN=1.
// Revision : 1.0
// ============================================================================
module tb_util_fifo_axis_reader;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vec_t;

    int          PL [2] = '{4, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr   [2];
    logic        flush [2];
    logic        wr_en [2];
    logic [31:0] wr_data [2];
    logic        tready [2];

    logic [31:0] fmem [2][256];
    logic [7:0]  wp [2];
    logic [7:0]  rp [2];
    logic [7:0]  cnt [2];

    logic        rden [2];
    logic        tv   [2];
    logic        tl   [2];
    logic [31:0] td   [2];
    logic        pdn  [2];

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    int          nb   [2] = '{0, 0};
    int          hcnt [2] = '{0, 0};
    int          dpc  [2] = '{0, 0};

    logic        pv [2], pr [2], pl [2], pc [2], pdone [2];
    logic [31:0] pd [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vec [16];

    always #5 clk = ~clk;

    util_fifo_axis_reader_if #(.DATA_WIDTH(32), .DEPTH(128)) ifa ();
    util_fifo_axis_reader_if #(.DATA_WIDTH(32), .DEPTH(128)) ifb ();

    util_fifo_axis_reader #(.DATA_WIDTH(32), .DEPTH(128), .PKT_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .bus(ifa));
    util_fifo_axis_reader #(.DATA_WIDTH(32), .DEPTH(128), .PKT_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .bus(ifb));

    assign ifa.fifo_dout     = fmem[0][rp[0]];
    assign ifa.fifo_dcnt     = cnt[0];
    assign ifa.fifo_empty    = (cnt[0] == 8'd0);
    assign ifa.m_axis_tready = tready[0];
    assign ifb.fifo_dout     = fmem[1][rp[1]];
    assign ifb.fifo_dcnt     = cnt[1];
    assign ifb.fifo_empty    = (cnt[1] == 8'd0);
    assign ifb.m_axis_tready = tready[1];

    assign rden[0] = ifa.fifo_rden;     assign rden[1] = ifb.fifo_rden;
    assign tv[0]   = ifa.m_axis_tvalid; assign tv[1]   = ifb.m_axis_tvalid;
    assign tl[0]   = ifa.m_axis_tlast;  assign tl[1]   = ifb.m_axis_tlast;
    assign td[0]   = ifa.m_axis_tdata;  assign td[1]   = ifb.m_axis_tdata;
    assign pdn[0]  = ifa.pkt_done;      assign pdn[1]  = ifb.pkt_done;

    // Show-ahead FIFO models feeding each instance.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (flush[k]) begin
                wp[k]  <= 8'd0;
                rp[k]  <= 8'd0;
                cnt[k] <= 8'd0;
            end else begin
                if (wr_en[k]) begin
                    fmem[k][wp[k]] <= wr_data[k];
                    wp[k]          <= wp[k] + 8'd1;
                end
                if (rden[k]) rp[k] <= rp[k] + 8'd1;
                cnt[k] <= cnt[k] + 8'(wr_en[k]) - 8'(rden[k]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic exp_last(input int k);
        return (nb[k] == PL[k] - 1);
    endfunction

    task automatic push_exp(input int k, input logic [31:0] d, input logic l);
        if (k == 0) q0.push_back({l, d});
        else        q1.push_back({l, d});
        nb[k] = l ? 0 : nb[k] + 1;
    endtask

    task automatic write_word(input int k, input logic [31:0] d, input logic l);
        push_exp(k, d, l);
        wr_en[k]   = 1'b1;
        wr_data[k] = d;
        @(posedge clk); #1;
        wr_en[k]   = 1'b0;
    endtask

    task automatic drain(input int k, input int budget, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (qsize(k) == 0 && !tv[k]) ok = 1'b1;
        end
        chk(nm, ok, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Scoreboard, AXIS hold rule, pkt_done timing and never-pop-empty checks.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        edone;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                if (rden[k]) chk("rden_on_empty", cnt[k] == 8'd0, 1'b0);
                if (pv[k] && !pr[k] && !pc[k])
                    chk("axis_hold", {tv[k], tl[k], td[k]}, {1'b1, pl[k], pd[k]});
                edone = pc[k] ? 1'b0 : pdone[k];
                if (edone || pdn[k]) chk("pkt_done", pdn[k], edone);
                if (pdn[k]) dpc[k]++;
                pdone[k] = 1'b0;
                if (tv[k] && tready[k]) begin
                    hcnt[k]++;
                    if (qsize(k) == 0) begin
                        chk("unexpected_beat", td[k], 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("beat_data", td[k], e[31:0]);
                        chk("beat_last", tl[k], e[32]);
                        pdone[k] = e[32];
                    end
                end
            end
            pv[k] = tv[k];
            pr[k] = tready[k];
            pd[k] = td[k];
            pl[k] = tl[k];
            pc[k] = clr[k] | ~rst_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int          base;
        int          dbase;
        logic [31:0] frozen;
        logic        hit;

        for (int i = 0; i < 16; i++) begin
            vec[i].data = (i < 8) ? 32'h10 + 32'(i) : 32'h20 + 32'(i - 8);
            vec[i].last = ((i % 4) == 3);
        end

        rst_n  = 1'b0;
        clr    = '{1'b0, 1'b0};
        flush  = '{1'b1, 1'b1};
        wr_en  = '{1'b0, 1'b0};
        wr_data = '{32'h0, 32'h0};
        tready = '{1'b1, 1'b1};
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; pr[k] = 1'b0; pl[k] = 1'b0; pc[k] = 1'b1; pdone[k] = 1'b0; pd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1 flush = '{1'b0, 1'b0};

        // Reset state, with a word already waiting in instance B's FIFO.
        write_word(1, 32'hB0, 1'b1);
        @(negedge clk);
        chk("rst_rden_b", rden[1], 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tvalid", tv[k], 1'b0);
            chk("rst_tlast", tl[k], 1'b0);
            chk("rst_tdata", td[k], 32'h0);
            chk("rst_pkt_done", pdn[k], 1'b0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        drain(1, 50, "rst_word_b_drain");

        // T1: preload 8 words under clr, then stream two packets.
        clr[0] = 1'b1;
        dbase  = dpc[0];
        for (int i = 0; i < 8; i++) write_word(0, vec[i].data, vec[i].last);
        @(negedge clk);
        chk("t1_clr_no_rden", rden[0], 1'b0);
        @(posedge clk); #1 clr[0] = 1'b0;
        drain(0, 100, "t1_drain");
        chk("t1_pkt_done_count", 64'(dpc[0] - dbase), 64'd2);

        // T2: 5-cycle tready stall mid-stream.
        dbase = dpc[0];
        base  = hcnt[0];
        fork
            begin
                for (int i = 8; i < 16; i++) write_word(0, vec[i].data, vec[i].last);
            end
            begin
                hit = 1'b0;
                for (int i = 0; i < 200 && !hit; i++) begin
                    @(posedge clk);
                    if (hcnt[0] >= base + 3) hit = 1'b1;
                end
                chk("t2_reach_stall", hit, 1'b1);
                #1 tready[0] = 1'b0;
                for (int s = 1; s <= 5; s++) begin
                    @(negedge clk);
                    if (s == 2) frozen = td[0];
                    if (s >= 4) begin
                        chk("t2_stall_rden", rden[0], 1'b0);
                        chk("t2_stall_tvalid", tv[0], 1'b1);
                    end
                end
                chk("t2_tdata_frozen", td[0], frozen);
                @(posedge clk); #1 tready[0] = 1'b1;
            end
        join
        drain(0, 100, "t2_drain");
        chk("t2_pkt_done_count", 64'(dpc[0] - dbase), 64'd2);

`ifdef UTIL_FIFO_RD_PKTWAIT_EN
        // T3: three words are not a packet; the fourth releases it.
        dbase = dpc[0];
        for (int i = 0; i < 3; i++) write_word(0, 32'h10 + 32'(i), exp_last(0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_wait_no_tvalid", tv[0], 1'b0);
        end
        @(posedge clk); #1;
        write_word(0, 32'h13, exp_last(0));
        drain(0, 100, "t3_drain");
        chk("t3_pkt_done_count", 64'(dpc[0] - dbase), 64'd1);
`else
        // T4: single word into an empty FIFO; pop at N+1, tvalid at N+2.
        push_exp(0, 32'hA5, exp_last(0));
        wr_en[0]   = 1'b1;
        wr_data[0] = 32'hA5;
        @(negedge clk);
        chk("t4_rden_n", rden[0], 1'b0);
        @(posedge clk); #1 wr_en[0] = 1'b0;
        @(negedge clk);
        chk("t4_rden_n1", rden[0], 1'b1);
        chk("t4_tvalid_n1", tv[0], 1'b0);
        @(negedge clk);
        chk("t4_tvalid_n2", tv[0], 1'b1);
        chk("t4_tdata_n2", td[0], 32'hA5);
        drain(0, 50, "t4_drain");
`endif

        // T5: clr after two beats discards the rest and restarts the beat count.
        tready[0] = 1'b0;
        for (int i = 0; i < 4; i++) write_word(0, 32'h50 + 32'(i), exp_last(0));
        base = hcnt[0];
        tready[0] = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            if (hcnt[0] >= base + 2) hit = 1'b1;
        end
        chk("t5_two_beats", hit, 1'b1);
        #1;
        tready[0] = 1'b0;
        clr[0]    = 1'b1;
        flush[0]  = 1'b1;
        q0.delete();
        nb[0] = 0;
        @(posedge clk); #1;
        clr[0]   = 1'b0;
        flush[0] = 1'b0;
        @(negedge clk);
        chk("t5_tvalid_after_clr", tv[0], 1'b0);
        chk("t5_pkt_done_after_clr", pdn[0], 1'b0);
        @(posedge clk); #1;
        tready[0] = 1'b1;
        dbase = dpc[0];
        for (int i = 0; i < 4; i++) write_word(0, 32'h60 + 32'(i), exp_last(0));
        drain(0, 100, "t5_drain");
        chk("t5_pkt_done_count", 64'(dpc[0] - dbase), 64'd1);

        // T6: PKT_LEN=1 instance, 100 random words under random backpressure.
        begin
            int sent;
            sent = 0;
            hit  = 1'b0;
            for (int c = 0; c < 3000 && !hit; c++) begin
                tready[1] = 1'($urandom_range(0, 1));
                if (sent < 100 && $urandom_range(0, 3) != 0) begin
                    push_exp(1, $urandom, 1'b1);
                    wr_en[1]   = 1'b1;
                    wr_data[1] = (q1.size() > 0) ? q1[q1.size() - 1][31:0] : 32'h0;
                    sent++;
                end else begin
                    wr_en[1] = 1'b0;
                end
                @(posedge clk); #1;
                if (sent == 100 && !wr_en[1] && q1.size() == 0 && !tv[1]) hit = 1'b1;
            end
            wr_en[1]  = 1'b0;
            tready[1] = 1'b1;
            chk("t6_all_sent", 64'(sent), 64'd100);
        end
        drain(1, 500, "t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
